// File: rtl/multicycle_control_fsm_pkg.sv
// Shared control-path definitions for the multi-cycle RISC-V sequencer:
// state encoding, decoded opcodes, ALU operation codes and the strobe decode.
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } ctrl_state_e;

  localparam logic [2:0] OP_R   = 3'b000;
  localparam logic [2:0] OP_I   = 3'b001;
  localparam logic [2:0] OP_LD  = 3'b010;
  localparam logic [2:0] OP_SD  = 3'b011;
  localparam logic [2:0] OP_BEQ = 3'b110;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // Datapath strobe bundle, MSB first in this order.
  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       beq;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctrl_strobe_t;

  localparam ctrl_strobe_t STROBE_NONE = 10'b00_0000_0000;

  function automatic logic is_legal_op(input logic [2:0] op);
    logic ok;
    case (op)
      OP_R, OP_I, OP_LD, OP_SD, OP_BEQ: ok = 1'b1;
      default:                          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Strobes for a given state and latched opcode. Evaluated on the next
  // state so the result can be registered and still line up with the state.
  function automatic ctrl_strobe_t decode_strobes(input ctrl_state_e st,
                                                  input logic [2:0]  op);
    ctrl_strobe_t s;
    s = STROBE_NONE;
    case (st)
      ST_FETCH: begin
        s.pc_write = 1'b1;
        s.ir_write = 1'b1;
      end
      ST_EXEC: begin
        case (op)
          OP_R: s.alu_op = ALU_FUNCT;
          OP_I: begin
            s.alu_op  = ALU_FUNCT;
            s.alu_src = 1'b1;
          end
          OP_LD, OP_SD: begin
            s.alu_op  = ALU_ADD;
            s.alu_src = 1'b1;
          end
          OP_BEQ: begin
            s.alu_op = ALU_SUB;
            s.beq    = 1'b1;
          end
          default: s = STROBE_NONE;
        endcase
      end
      ST_MEM: begin
        // Address stays on the ALU output for the whole memory access.
        s.alu_src = 1'b1;
        s.alu_op  = ALU_ADD;
        if (op == OP_LD) begin
          s.mem_read = 1'b1;
        end else begin
          s.mem_write = 1'b1;
        end
      end
      ST_WB: begin
        s.reg_write = 1'b1;
        if (op == OP_LD) begin
          s.mem_to_reg = 1'b1;
        end else if (op == OP_I) begin
          s.alu_op  = ALU_FUNCT;
          s.alu_src = 1'b1;
        end else begin
          s.alu_op = ALU_FUNCT;
        end
      end
      default: s = STROBE_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Sequencer <-> datapath bundle: run/opcode/memory handshake in, strobes and
// status out. The sequencer uses the master view, the datapath the slave view.
interface multicycle_control_fsm_if #(
  parameter int NumInst = 7
) ();
  localparam int CntW = $clog2(NumInst + 1);

  logic            run;
  logic [2:0]      Opcode;
  logic            mem_ready;
  logic            pc_write;
  logic            ir_write;
  logic            beq;
  logic            mem_read;
  logic            mem_write;
  logic            alu_src;
  logic            mem_to_reg;
  logic            reg_write;
  logic [1:0]      alu_op;
  logic [CntW-1:0] retired;
  logic            done;
  logic            illegal;

  modport master (
    input  run, Opcode, mem_ready,
    output pc_write, ir_write, beq, mem_read, mem_write, alu_src,
           mem_to_reg, reg_write, alu_op, retired, done, illegal
  );

  modport slave (
    output run, Opcode, mem_ready,
    input  pc_write, ir_write, beq, mem_read, mem_write, alu_src,
           mem_to_reg, reg_write, alu_op, retired, done, illegal
  );
endinterface

// File: rtl/multicycle_control_fsm_retire_counter.sv
// Retired-instruction counter. Saturates at NumInst, flags the last
// instruction before it retires, and keeps a sticky terminal flag.
module instr_retire_counter #(
  parameter int NumInst = 7,
  parameter int CntW    = $clog2(NumInst + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  output logic [CntW-1:0] count,
  output logic            last,
  output logic            full
);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(NumInst);
  localparam logic [CntW-1:0] LastCnt = CntW'(NumInst - 1);
  localparam logic [CntW-1:0] OneCnt  = CntW'(1);

  logic [CntW-1:0] count_q, count_d;
  logic            full_q, full_d;

  // Saturating increment; terminal flag set when the final instruction retires
  always_comb begin
    count_d = count_q;
    full_d  = full_q;
    if (inc && (count_q != MaxCnt)) begin
      count_d = count_q + OneCnt;
      if (count_q == LastCnt) begin
        full_d = 1'b1;
      end else begin
        full_d = full_q;
      end
    end else begin
      count_d = count_q;
    end
  end

  // Count and terminal-flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= {CntW{1'b0}};
      full_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  assign count = count_q;
  assign last  = (count_q == LastCnt);
  assign full  = full_q;
endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB per instruction,
// memory-ready stalls, retire counting and halt after NumInst instructions.
// All outputs come straight from flops; strobes are registered from the
// next-state decode so they line up with the state they belong to.
module multicycle_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int NumInst = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  multicycle_control_fsm_if.master bus
);
  localparam int CntW = $clog2(NumInst + 1);

  ctrl_state_e     state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic            illegal_q, illegal_d;
  ctrl_strobe_t    strobe_q, strobe_d;
  logic            retire_s;
  logic            last_s;
  logic            full_s;
  logic [CntW-1:0] retired_s;

  // Next-state, opcode latch and illegal-opcode detection
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    retire_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.run) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        op_d = bus.Opcode;
        if (is_legal_op(bus.Opcode)) begin
          state_d = ST_EXEC;
        end else begin
          state_d   = ST_HALT;
          illegal_d = 1'b1;
        end
      end
      ST_EXEC: begin
        case (op_q)
          OP_R, OP_I:   state_d  = ST_WB;
          OP_LD, OP_SD: state_d  = ST_MEM;
          OP_BEQ:       retire_s = 1'b1;
          default:      state_d  = ST_HALT;
        endcase
      end
      ST_MEM: begin
        // Stall here until the data memory completes the access.
        if (bus.mem_ready) begin
          if (op_q == OP_LD) begin
            state_d = ST_WB;
          end else begin
            retire_s = 1'b1;
          end
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WB:   retire_s = 1'b1;
      ST_HALT: state_d  = ST_HALT;
      default: state_d  = ST_IDLE;
    endcase

    // Instruction boundary: halt on the final retire, else follow run.
    if (retire_s) begin
      if (last_s) begin
        state_d = ST_HALT;
      end else if (bus.run) begin
        state_d = ST_FETCH;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      state_d = state_d;
    end
  end

  assign strobe_d = decode_strobes(state_d, op_d);

  // State, latched opcode, sticky illegal flag and registered strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_R;
      illegal_q <= 1'b0;
      strobe_q  <= STROBE_NONE;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
      strobe_q  <= strobe_d;
    end
  end

  instr_retire_counter #(
    .NumInst (NumInst),
    .CntW    (CntW)
  ) u_retire_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (retire_s),
    .count (retired_s),
    .last  (last_s),
    .full  (full_s)
  );

  assign bus.pc_write   = strobe_q.pc_write;
  assign bus.ir_write   = strobe_q.ir_write;
  assign bus.beq        = strobe_q.beq;
  assign bus.mem_read   = strobe_q.mem_read;
  assign bus.mem_write  = strobe_q.mem_write;
  assign bus.alu_src    = strobe_q.alu_src;
  assign bus.mem_to_reg = strobe_q.mem_to_reg;
  assign bus.reg_write  = strobe_q.reg_write;
  assign bus.alu_op     = strobe_q.alu_op;
  assign bus.retired    = retired_s;
  assign bus.done       = full_s;
  assign bus.illegal    = illegal_q;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm with NumInst = 3. Each vector gives the
// inputs for one clock cycle and the outputs expected during that cycle.
module tb_multicycle_control_fsm;

  localparam int N = 3;

  // Strobe order: pc_write ir_write beq mem_read mem_write alu_src mem_to_reg reg_write alu_op[1:0]
  localparam logic [9:0] X_NONE = 10'b00_0_0_0_0_0_0_00;
  localparam logic [9:0] X_FET  = 10'b11_0_0_0_0_0_0_00;
  localparam logic [9:0] X_EXR  = 10'b00_0_0_0_0_0_0_10;
  localparam logic [9:0] X_EXI  = 10'b00_0_0_0_1_0_0_10;
  localparam logic [9:0] X_EXM  = 10'b00_0_0_0_1_0_0_00;
  localparam logic [9:0] X_EXB  = 10'b00_1_0_0_0_0_0_01;
  localparam logic [9:0] X_MRD  = 10'b00_0_1_0_1_0_0_00;
  localparam logic [9:0] X_MWR  = 10'b00_0_0_1_1_0_0_00;
  localparam logic [9:0] X_WBR  = 10'b00_0_0_0_0_0_1_10;
  localparam logic [9:0] X_WBI  = 10'b00_0_0_0_1_0_1_10;
  localparam logic [9:0] X_WBL  = 10'b00_0_0_0_0_1_1_00;

  localparam logic [2:0] O_R   = 3'b000;
  localparam logic [2:0] O_I   = 3'b001;
  localparam logic [2:0] O_LD  = 3'b010;
  localparam logic [2:0] O_SD  = 3'b011;
  localparam logic [2:0] O_BEQ = 3'b110;
  localparam logic [2:0] O_BAD = 3'b111;

  typedef struct packed {
    logic       rst_v;
    logic       run_v;
    logic [2:0] op_v;
    logic       rdy_v;
    logic [9:0] strb;
    logic [1:0] ret;
    logic       done_v;
    logic       ill_v;
  } vec_t;

  typedef struct packed {
    logic [9:0] strb;
    logic [1:0] ret;
    logic       done_v;
    logic       ill_v;
  } exp_t;

  logic clk;
  logic rst;
  vec_t vec_q[$];
  exp_t exp_q[$];
  int   checks;
  int   errors;

  multicycle_control_fsm_if #(.NumInst(N)) bus ();

  multicycle_control_fsm #(.NumInst(N)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] act_strb();
    return {bus.pc_write, bus.ir_write, bus.beq, bus.mem_read, bus.mem_write,
            bus.alu_src, bus.mem_to_reg, bus.reg_write, bus.alu_op};
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s vec %0d got %0h expected %0h", name, idx, got, exp);
    end
  endtask

  task automatic add(input logic r, input logic ru, input logic [2:0] op,
                     input logic rd, input logic [9:0] s, input logic [1:0] rt,
                     input logic d, input logic il);
    vec_t v;
    v = '{rst_v: r, run_v: ru, op_v: op, rdy_v: rd, strb: s, ret: rt,
          done_v: d, ill_v: il};
    vec_q.push_back(v);
  endtask

  task automatic add_reset();
    add(1'b0, 1'b0, O_R, 1'b0, X_NONE, 2'd0, 1'b0, 1'b0);
    add(1'b0, 1'b1, O_R, 1'b1, X_NONE, 2'd0, 1'b0, 1'b0);
  endtask

  // Drive one cycle's inputs after the rising edge, score outputs on the falling edge.
  task automatic apply_vec(input vec_t v, input int idx);
    exp_t e;
    @(posedge clk);
    #1;
    rst           = v.rst_v;
    bus.run       = v.run_v;
    bus.Opcode    = v.op_v;
    bus.mem_ready = v.rdy_v;
    exp_q.push_back('{strb: v.strb, ret: v.ret, done_v: v.done_v, ill_v: v.ill_v});
    @(negedge clk);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty vec %0d got 0 expected 1", idx);
    end else begin
      e = exp_q.pop_front();
      check("strobes", idx, 32'(act_strb()), 32'(e.strb));
      check("retired", idx, 32'(bus.retired), 32'(e.ret));
      check("done", idx, 32'(bus.done), 32'(e.done_v));
      check("illegal", idx, 32'(bus.illegal), 32'(e.ill_v));
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b0;
    bus.run       = 1'b0;
    bus.Opcode    = O_R;
    bus.mem_ready = 1'b0;

    // R-type stream: reg_write in cycles 4, 8, 12, then halt with done.
    add_reset();
    add(1'b1, 1'b1, O_R, 1'b1, X_NONE, 2'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      add(1'b1, 1'b1, O_R, 1'b1, X_FET, 2'(k), 1'b0, 1'b0);
      add(1'b1, 1'b1, O_R, 1'b1, X_NONE, 2'(k), 1'b0, 1'b0);
      add(1'b1, 1'b1, O_R, 1'b1, X_EXR, 2'(k), 1'b0, 1'b0);
      add(1'b1, 1'b1, O_R, 1'b1, X_WBR, 2'(k), 1'b0, 1'b0);
    end
    add(1'b1, 1'b1, O_R, 1'b1, X_NONE, 2'd3, 1'b1, 1'b0);
    add(1'b1, 1'b1, O_R, 1'b1, X_NONE, 2'd3, 1'b1, 1'b0);

    // ld with three wait states (mem_ready high outside MEM is ignored), sd with one, then beq.
    add_reset();
    add(1'b1, 1'b1, O_LD, 1'b0, X_NONE, 2'd0, 1'b0, 1'b0);
    add(1'b1, 1'b1, O_LD, 1'b1, X_FET, 2'd0, 1'b0, 1'b0);
    add(1'b1, 1'b1, O_LD, 1'b1, X_NONE, 2'd0, 1'b0, 1'b0);
    add(1'b1, 1'b1, O_LD, 1'b1, X_EXM, 2'd0, 1'b0, 1'b0);
    add(1'b1, 1'b1, O_LD, 1'b0, X_MRD, 2'd0, 1'b0, 1'b0);
    add(1'b1, 1'b1, O_LD, 1'b0, X_MRD, 2'd0, 1'b0, 1'b0);
    add(1'b1, 1'b1, O_LD, 1'b0, X_MRD, 2'd0, 1'b0, 1'b0);
    add(1'b1, 1'b1, O_LD, 1'b1, X_MRD, 2'd0, 1'b0, 1'b0);
    add(1'b1, 1'b1, O_LD, 1'b0, X_WBL, 2'd0, 1'b0, 1'b0);
    add(1'b1, 1'b1, O_SD, 1'b1, X_FET, 2'd1, 1'b0, 1'b0);
    add(1'b1, 1'b1, O_SD, 1'b1, X_NONE, 2'd1, 1'b0, 1'b0);
    add(1'b1, 1'b1, O_SD, 1'b1, X_EXM, 2'd1, 1'b0, 1'b0);
    add(1'b1, 1'b1, O_SD, 1'b0, X_MWR, 2'd1, 1'b0, 1'b0);
    add(1'b1, 1'b1, O_SD, 1'b1, X_MWR, 2'd1, 1'b0, 1'b0);
    add(1'b1, 1'b1, O_BEQ, 1'b0, X_FET, 2'd2, 1'b0, 1'b0);
    add(1'b1, 1'b1, O_BEQ, 1'b0, X_NONE, 2'd2, 1'b0, 1'b0);
    add(1'b1, 1'b1, O_BEQ, 1'b0, X_EXB, 2'd2, 1'b0, 1'b0);
    add(1'b1, 1'b1, O_BEQ, 1'b0, X_NONE, 2'd3, 1'b1, 1'b0);
    add(1'b1, 1'b1, O_R, 1'b1, X_NONE, 2'd3, 1'b1, 1'b0);

    // Illegal opcode after one retired R-type: halt, retired stays 1.
    add_reset();
    add(1'b1, 1'b1, O_R, 1'b0, X_NONE, 2'd0, 1'b0, 1'b0);
    add(1'b1, 1'b1, O_R, 1'b0, X_FET, 2'd0, 1'b0, 1'b0);
    add(1'b1, 1'b1, O_R, 1'b0, X_NONE, 2'd0, 1'b0, 1'b0);
    add(1'b1, 1'b1, O_R, 1'b0, X_EXR, 2'd0, 1'b0, 1'b0);
    add(1'b1, 1'b1, O_R, 1'b0, X_WBR, 2'd0, 1'b0, 1'b0);
    add(1'b1, 1'b1, O_BAD, 1'b0, X_FET, 2'd1, 1'b0, 1'b0);
    add(1'b1, 1'b1, O_BAD, 1'b0, X_NONE, 2'd1, 1'b0, 1'b0);
    add(1'b1, 1'b1, O_BAD, 1'b0, X_NONE, 2'd1, 1'b0, 1'b1);
    add(1'b1, 1'b1, O_R, 1'b1, X_NONE, 2'd1, 1'b0, 1'b1);

    // run dropped mid-instruction: I-type completes, FSM idles, restarts on run.
    add_reset();
    add(1'b1, 1'b1, O_I, 1'b0, X_NONE, 2'd0, 1'b0, 1'b0);
    add(1'b1, 1'b1, O_I, 1'b0, X_FET, 2'd0, 1'b0, 1'b0);
    add(1'b1, 1'b1, O_I, 1'b0, X_NONE, 2'd0, 1'b0, 1'b0);
    add(1'b1, 1'b0, O_I, 1'b0, X_EXI, 2'd0, 1'b0, 1'b0);
    add(1'b1, 1'b0, O_I, 1'b0, X_WBI, 2'd0, 1'b0, 1'b0);
    add(1'b1, 1'b0, O_I, 1'b0, X_NONE, 2'd1, 1'b0, 1'b0);
    add(1'b1, 1'b1, O_BEQ, 1'b0, X_NONE, 2'd1, 1'b0, 1'b0);
    add(1'b1, 1'b0, O_BEQ, 1'b0, X_FET, 2'd1, 1'b0, 1'b0);
    add(1'b1, 1'b0, O_BEQ, 1'b0, X_NONE, 2'd1, 1'b0, 1'b0);
    add(1'b1, 1'b0, O_BEQ, 1'b0, X_EXB, 2'd1, 1'b0, 1'b0);
    add(1'b1, 1'b0, O_BEQ, 1'b0, X_NONE, 2'd2, 1'b0, 1'b0);

    // Lead-in to reset during a load: one R-type retires, ld reaches its first MEM wait.
    add_reset();
    add(1'b1, 1'b1, O_R, 1'b0, X_NONE, 2'd0, 1'b0, 1'b0);
    add(1'b1, 1'b1, O_R, 1'b0, X_FET, 2'd0, 1'b0, 1'b0);
    add(1'b1, 1'b1, O_R, 1'b0, X_NONE, 2'd0, 1'b0, 1'b0);
    add(1'b1, 1'b1, O_R, 1'b0, X_EXR, 2'd0, 1'b0, 1'b0);
    add(1'b1, 1'b1, O_R, 1'b0, X_WBR, 2'd0, 1'b0, 1'b0);
    add(1'b1, 1'b1, O_LD, 1'b0, X_FET, 2'd1, 1'b0, 1'b0);
    add(1'b1, 1'b1, O_LD, 1'b0, X_NONE, 2'd1, 1'b0, 1'b0);
    add(1'b1, 1'b1, O_LD, 1'b0, X_EXM, 2'd1, 1'b0, 1'b0);
    add(1'b1, 1'b1, O_LD, 1'b0, X_MRD, 2'd1, 1'b0, 1'b0);

    for (int i = 0; i < vec_q.size(); i++) begin
      apply_vec(vec_q[i], i);
    end

    // Second MEM wait cycle of the load: reset must clear everything within the cycle.
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b0;
    check("pre_reset_mem_read", 1000, 32'(bus.mem_read), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("reset_strobes", 1001, 32'(act_strb()), 32'(X_NONE));
    check("reset_retired", 1002, 32'(bus.retired), 32'd0);
    check("reset_done", 1003, 32'(bus.done), 32'd0);
    check("reset_illegal", 1004, 32'(bus.illegal), 32'd0);
    @(negedge clk);

    // Clean restart after that reset.
    vec_q.delete();
    add(1'b1, 1'b1, O_R, 1'b0, X_NONE, 2'd0, 1'b0, 1'b0);
    add(1'b1, 1'b1, O_R, 1'b0, X_FET, 2'd0, 1'b0, 1'b0);
    add(1'b1, 1'b1, O_R, 1'b0, X_NONE, 2'd0, 1'b0, 1'b0);
    add(1'b1, 1'b1, O_R, 1'b0, X_EXR, 2'd0, 1'b0, 1'b0);
    add(1'b1, 1'b1, O_R, 1'b0, X_WBR, 2'd0, 1'b0, 1'b0);
    add(1'b1, 1'b0, O_R, 1'b0, X_FET, 2'd1, 1'b0, 1'b0);
    for (int i = 0; i < vec_q.size(); i++) begin
      apply_vec(vec_q[i], 2000 + i);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
